// File: rtl/intf_arb_pkg.sv
// Shared types and helpers for the round-robin interface arbiter.
package intf_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_GRANT = 2'd1,
    ARB_GAP   = 2'd2
  } arb_state_t;

  localparam int unsigned ARB_NREQ_DEF     = 4;
  localparam int unsigned ARB_HOLD_MAX_DEF = 8;

  // $clog2 clamped to a minimum of 1 so single-entry indices stay legal
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 32'd1) ? 32'd1 : 32'($clog2(n));
  endfunction

endpackage

// File: rtl/intf_arb_pick.sv
// Combinational round-robin picker: first set request at or after i_ptr,
// searching circularly upward (rotate, find-first-set, un-rotate).
module intf_arb_pick
  import intf_arb_pkg::*;
#(
  parameter int unsigned NREQ = ARB_NREQ_DEF,
  parameter int unsigned IDW  = clog2_min1(NREQ)
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IDW-1:0]  i_ptr,
  output logic [IDW-1:0]  o_sel,
  output logic            o_any_req
);

  localparam int unsigned SW = IDW + 1;

  logic [NREQ-1:0] w_rot;
  logic [IDW-1:0]  w_first;
  logic            w_found;
  logic [SW-1:0]   w_usum;
  logic [SW-1:0]   w_uidx;

  genvar g;
  generate
    for (g = 0; g < NREQ; g++) begin : g_rot
      logic [SW-1:0] w_sum;
      logic [SW-1:0] w_idx;
      assign w_sum    = SW'(g) + SW'(i_ptr);
      assign w_idx    = (w_sum >= SW'(NREQ)) ? (w_sum - SW'(NREQ)) : w_sum;
      assign w_rot[g] = i_req[IDW'(w_idx)];
    end
  endgenerate

  always_comb begin
    w_first = '0;
    w_found = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (!w_found && w_rot[i]) begin
        w_first = IDW'(i);
        w_found = 1'b1;
      end
    end
  end

  assign w_usum    = SW'(w_first) + SW'(i_ptr);
  assign w_uidx    = (w_usum >= SW'(NREQ)) ? (w_usum - SW'(NREQ)) : w_usum;
  assign o_sel     = IDW'(w_uidx);
  assign o_any_req = |i_req;

endmodule

// File: rtl/intf_rr_arbiter.sv
// Round-robin owner arbiter for a single-owner shared interface: grant,
// release, one turnaround cycle. Optional grant limit: INTF_RR_ARBITER_TIMEOUT_EN.
module intf_rr_arbiter
  import intf_arb_pkg::*;
#(
  parameter int unsigned NREQ     = ARB_NREQ_DEF,
  parameter int unsigned IDW      = clog2_min1(NREQ),
  parameter int unsigned HOLD_MAX = ARB_HOLD_MAX_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] done,
  output logic [NREQ-1:0] gnt,
  output logic            gnt_valid,
  output logic [IDW-1:0]  gnt_id,
  output logic            busy,
  output logic            timeout
);

  arb_state_t      r_state, w_state_nxt;
  logic [IDW-1:0]  r_ptr, w_ptr_nxt;
  logic [NREQ-1:0] r_gnt, w_gnt_nxt;
  logic            r_gnt_valid;
  logic [IDW-1:0]  r_gnt_id, w_gnt_id_nxt;
  logic            r_busy;
  logic [IDW-1:0]  w_sel;
  logic            w_any_req;
  logic            w_release;
  logic            w_drop;
  logic [IDW-1:0]  w_ptr_inc;

`ifdef INTF_RR_ARBITER_TIMEOUT_EN
  localparam int unsigned CNTW = clog2_min1(HOLD_MAX);
  logic [CNTW-1:0] r_cnt, w_cnt_nxt;
  logic            r_timeout, w_timeout_nxt;
  logic            w_force;
`endif

  intf_arb_pick #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_pick (
    .i_req     (req),
    .i_ptr     (r_ptr),
    .o_sel     (w_sel),
    .o_any_req (w_any_req)
  );

  // Owner gives up the bus by pulsing done or dropping its request
  assign w_release = done[r_gnt_id] | ~req[r_gnt_id];
  assign w_ptr_inc = (r_gnt_id == IDW'(NREQ - 1)) ? '0 : r_gnt_id + IDW'(1);

  always_comb begin
    w_state_nxt  = r_state;
    w_ptr_nxt    = r_ptr;
    w_gnt_nxt    = r_gnt;
    w_gnt_id_nxt = r_gnt_id;
    w_drop       = w_release;
`ifdef INTF_RR_ARBITER_TIMEOUT_EN
    w_cnt_nxt     = r_cnt;
    w_timeout_nxt = 1'b0;
    w_force       = 1'b0;
`endif
    case (r_state)
      ARB_IDLE: begin
        w_gnt_nxt = '0;
        if (w_any_req) begin
          w_gnt_nxt    = NREQ'(1) << w_sel;
          w_gnt_id_nxt = w_sel;
          w_state_nxt  = ARB_GRANT;
`ifdef INTF_RR_ARBITER_TIMEOUT_EN
          w_cnt_nxt = '0;
`endif
        end
      end
      ARB_GRANT: begin
`ifdef INTF_RR_ARBITER_TIMEOUT_EN
        // A voluntary release in the limit cycle takes precedence
        w_force = !w_release && (r_cnt == CNTW'(HOLD_MAX - 1));
        w_drop  = w_release | w_force;
`endif
        if (w_drop) begin
          w_gnt_nxt   = '0;
          w_ptr_nxt   = w_ptr_inc;
          w_state_nxt = ARB_GAP;
`ifdef INTF_RR_ARBITER_TIMEOUT_EN
          w_timeout_nxt = w_force;
`endif
        end else begin
`ifdef INTF_RR_ARBITER_TIMEOUT_EN
          w_cnt_nxt = r_cnt + CNTW'(1);
`endif
        end
      end
      ARB_GAP: begin
        w_gnt_nxt   = '0;
        w_state_nxt = ARB_IDLE;
      end
      default: begin
        w_gnt_nxt   = '0;
        w_state_nxt = ARB_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ARB_IDLE;
      r_ptr       <= '0;
      r_gnt       <= '0;
      r_gnt_valid <= 1'b0;
      r_gnt_id    <= '0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_ptr       <= w_ptr_nxt;
      r_gnt       <= w_gnt_nxt;
      r_gnt_valid <= |w_gnt_nxt;
      r_gnt_id    <= w_gnt_id_nxt;
      r_busy      <= (w_state_nxt != ARB_IDLE);
    end
  end

`ifdef INTF_RR_ARBITER_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt     <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_cnt     <= w_cnt_nxt;
      r_timeout <= w_timeout_nxt;
    end
  end

  assign timeout = r_timeout;
`else
  logic w_unused_hold;
  assign w_unused_hold = ^(32'(HOLD_MAX));
  assign timeout       = 1'b0;
`endif

  assign gnt       = r_gnt;
  assign gnt_valid = r_gnt_valid;
  assign gnt_id    = r_gnt_id;
  assign busy      = r_busy;

endmodule

// File: tb/tb_intf_rr_arbiter.sv
// Self-checking bench for intf_rr_arbiter: directed table, corner sequences,
// and randomized traffic against a behavioural ownership model.
module tb_intf_rr_arbiter;

  localparam int N    = 4;
  localparam int HOLD = 8;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic [3:0] done;
  logic [3:0] gnt;
  logic       gnt_valid;
  logic [1:0] gnt_id;
  logic       busy;
  logic       timeout;

  intf_rr_arbiter #(
    .NREQ     (N),
    .HOLD_MAX (HOLD)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .done      (done),
    .gnt       (gnt),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id),
    .busy      (busy),
    .timeout   (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp;
  int n_bad;

  // Behavioural model: phase 0=idle 1=owned 2=turnaround
  int m_phase;
  int m_owner;
  int m_ptr;
  int m_last;
  int m_hold;
  bit m_to;

  typedef struct packed {
    logic [3:0] req;
    logic [3:0] done;
    logic [3:0] gnt;
    logic       busy;
    logic [1:0] id;
  } vec_t;

  vec_t tbl [11];

  function automatic void model_reset();
    m_phase = 0;
    m_owner = -1;
    m_ptr   = 0;
    m_last  = 0;
    m_hold  = 0;
    m_to    = 1'b0;
  endfunction

  function automatic void model_edge(input logic [3:0] r, input logic [3:0] d);
    int  pick;
    int  c;
    bit  rel;
    bit  forced;
    m_to = 1'b0;
    if (m_phase == 0) begin
      pick = -1;
      for (int k = 0; k < N; k++) begin
        c = (m_ptr + k) % N;
        if (pick < 0 && r[c]) pick = c;
      end
      if (pick >= 0) begin
        m_owner = pick;
        m_last  = pick;
        m_hold  = 0;
        m_phase = 1;
      end
    end else if (m_phase == 1) begin
      rel = d[m_owner] || !r[m_owner];
`ifdef INTF_RR_ARBITER_TIMEOUT_EN
      forced = !rel && (m_hold == HOLD - 1);
`else
      forced = 1'b0;
`endif
      if (rel || forced) begin
        m_ptr   = (m_owner + 1) % N;
        m_owner = -1;
        m_phase = 2;
        m_to    = forced;
      end else begin
        m_hold++;
      end
    end else begin
      m_phase = 0;
    end
  endfunction

  function automatic logic [8:0] exp_vec();
    logic [3:0] g;
    g = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0000;
    return {g, (m_owner >= 0), 2'(m_last), (m_phase != 0), m_to};
  endfunction

  function automatic logic [8:0] dut_vec();
    return {gnt, gnt_valid, gnt_id, busy, timeout};
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic step(input logic [3:0] r, input logic [3:0] d);
    @(negedge clk);
    req  = r;
    done = d;
    @(posedge clk);
    model_edge(r, d);
    #1;
    check("model", 32'(dut_vec()), 32'(exp_vec()));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst  = 1'b1;
    req  = '0;
    done = '0;
    model_reset();
    #1;
    check("reset", 32'(dut_vec()), 32'(9'd0));
    @(negedge clk);
    rst = 1'b0;
  endtask

  int order [5];
  int waits;
  int g0_cycles;
  int to_cnt;
  logic [3:0] rr;
  logic [3:0] dd;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst   = 1'b1;
    req   = '0;
    done  = '0;
    model_reset();

    tbl[0]  = '{req: 4'b0100, done: 4'b0000, gnt: 4'b0100, busy: 1'b1, id: 2'd2};
    tbl[1]  = '{req: 4'b0100, done: 4'b0100, gnt: 4'b0000, busy: 1'b1, id: 2'd2};
    tbl[2]  = '{req: 4'b0000, done: 4'b0000, gnt: 4'b0000, busy: 1'b0, id: 2'd2};
    tbl[3]  = '{req: 4'b1111, done: 4'b0000, gnt: 4'b1000, busy: 1'b1, id: 2'd3};
    tbl[4]  = '{req: 4'b1111, done: 4'b1000, gnt: 4'b0000, busy: 1'b1, id: 2'd3};
    tbl[5]  = '{req: 4'b1111, done: 4'b0000, gnt: 4'b0000, busy: 1'b0, id: 2'd3};
    tbl[6]  = '{req: 4'b1111, done: 4'b0000, gnt: 4'b0001, busy: 1'b1, id: 2'd0};
    tbl[7]  = '{req: 4'b1111, done: 4'b0010, gnt: 4'b0001, busy: 1'b1, id: 2'd0};
    tbl[8]  = '{req: 4'b1110, done: 4'b0000, gnt: 4'b0000, busy: 1'b1, id: 2'd0};
    tbl[9]  = '{req: 4'b1110, done: 4'b0000, gnt: 4'b0000, busy: 1'b0, id: 2'd0};
    tbl[10] = '{req: 4'b1110, done: 4'b0000, gnt: 4'b0010, busy: 1'b1, id: 2'd1};

    // Directed table
    do_reset();
    for (int i = 0; i < 11; i++) begin
      step(tbl[i].req, tbl[i].done);
      check($sformatf("tbl%0d", i), 32'({gnt, busy, gnt_id}),
            32'({tbl[i].gnt, tbl[i].busy, tbl[i].id}));
    end

    // Fairness with everyone requesting; done two cycles into each grant
    order[0] = 0; order[1] = 1; order[2] = 2; order[3] = 3; order[4] = 0;
    do_reset();
    for (int g = 0; g < 5; g++) begin
      waits = 0;
      step(4'b1111, 4'b0000);
      waits++;
      while (!gnt_valid && waits < 8) begin
        step(4'b1111, 4'b0000);
        waits++;
      end
      check($sformatf("rr_id%0d", g), 32'(gnt_id), 32'(order[g]));
      check($sformatf("rr_wait%0d", g), 32'(waits), (g == 0) ? 32'd1 : 32'd2);
      step(4'b1111, 4'b0000);
      step(4'b1111, 4'(1 << order[g]));
      check($sformatf("rr_gap%0d", g), 32'({gnt_valid, busy}), 32'(2'b01));
    end

    // Pointer wrap after owner 3
    do_reset();
    step(4'b1000, 4'b0000);
    check("wrap_own3", 32'(gnt), 32'(4'b1000));
    step(4'b1001, 4'b1000);
    step(4'b1001, 4'b0000);
    step(4'b1001, 4'b0000);
    check("wrap_to0", 32'(gnt), 32'(4'b0001));
    step(4'b1001, 4'b0001);
    step(4'b1001, 4'b0000);
    step(4'b1001, 4'b0000);
    check("after_wrap", 32'(gnt), 32'(4'b1000));

    // Asynchronous reset mid-grant, then pointer back at 0
    do_reset();
    step(4'b0100, 4'b0000);
    step(4'b0100, 4'b0100);
    step(4'b0010, 4'b0000);
    step(4'b0010, 4'b0000);
    check("pre_rst", 32'(gnt), 32'(4'b0010));
    #2;
    rst  = 1'b1;
    req  = '0;
    done = '0;
    model_reset();
    #1;
    check("async_rst", 32'(dut_vec()), 32'(9'd0));
    @(negedge clk);
    rst = 1'b0;
    step(4'b1010, 4'b0000);
    check("rst_ptr", 32'({gnt, gnt_id}), 32'({4'b0010, 2'd1}));

    // Long hold: bounded only when the grant limit is compiled in
    do_reset();
    g0_cycles = 0;
    to_cnt    = 0;
    for (int i = 0; i < 12; i++) begin
      step(4'b0011, 4'b0000);
      if (gnt == 4'b0001) g0_cycles++;
      if (timeout) to_cnt++;
    end
`ifdef INTF_RR_ARBITER_TIMEOUT_EN
    check("hold_len", 32'(g0_cycles), 32'(HOLD));
    check("timeout_cnt", 32'(to_cnt), 32'd1);
    check("next_after_to", 32'(gnt), 32'(4'b0010));
`else
    check("hold_len", 32'(g0_cycles), 32'd12);
    check("timeout_cnt", 32'(to_cnt), 32'd0);
`endif

    // Randomized traffic against the model
    do_reset();
    rr = '0;
    for (int i = 0; i < 400; i++) begin
      rr = rr ^ (4'($urandom) & 4'($urandom));
      dd = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000;
      step(rr, dd);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
